// File: rtl/lives_counter_pkg.sv
// Shared types and helpers for the monkey life bookkeeping block.
package lives_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAYING   = 3'd1,
    DYING     = 3'd2,
    INVULN    = 3'd3,
    GAME_OVER = 3'd4
  } lives_state_t;

  localparam int LIVES_W = 2;

  function automatic logic [LIVES_W-1:0] sat_dec(input logic [LIVES_W-1:0] v);
    return (v == {LIVES_W{1'b0}}) ? v : v - {{(LIVES_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [LIVES_W-1:0] sat_inc(input logic [LIVES_W-1:0] v,
                                                 input logic [LIVES_W-1:0] max_v);
    return (v >= max_v) ? max_v : v + {{(LIVES_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/lives_counter_if.sv
// Event inputs and display/control outputs of the lives counter.
interface lives_counter_if;
  import lives_pkg::*;

  logic               startOfFrame;
  logic               startGame;
  logic               collision;
  logic               bonusLife;
  logic [LIVES_W-1:0] numOfLives;
  logic               monkeyBlink;
  logic               freezeMonkey;
  logic               respawnPulse;
  logic               lifeLostPulse;
  logic               gameOver;

  modport master (
    output startOfFrame, startGame, collision, bonusLife,
    input  numOfLives, monkeyBlink, freezeMonkey, respawnPulse, lifeLostPulse, gameOver
  );

  modport slave (
    input  startOfFrame, startGame, collision, bonusLife,
    output numOfLives, monkeyBlink, freezeMonkey, respawnPulse, lifeLostPulse, gameOver
  );
endinterface

// File: rtl/lives_counter_frame_timer.sv
// Saturating startOfFrame counter shared by the DYING and INVULN windows.
module frame_timer #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             startOfFrame,
  input  logic [CNT_W-1:0] target,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Frame count: clear has priority, then count up and hold at all-ones
  always_ff @(posedge clk) begin
    if (resetN) begin
      count_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      count_r <= {CNT_W{1'b0}};
    end else if (startOfFrame && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign done  = (count_r >= target);

endmodule

// File: rtl/lives_counter.sv
// Monkey life sequencing: hit -> death pause -> invulnerable respawn -> game over.
// Optional macro LIVES_BONUS_EN enables bonusLife increments in PLAYING/INVULN.
module lives_counter
  import lives_pkg::*;
#(
  parameter int MAX_LIVES     = 3,
  parameter int DEATH_FRAMES  = 30,
  parameter int INVULN_FRAMES = 90,
  parameter int BLINK_SHIFT   = 3
) (
  input logic           clk,
  input logic           resetN,
  lives_counter_if.slave bus
);

  localparam int FRAME_MAX = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
  localparam int CNT_W     = $clog2(FRAME_MAX + 1);
  localparam logic [LIVES_W-1:0] MAX_L      = LIVES_W'(MAX_LIVES);
  localparam logic [CNT_W-1:0]   DEATH_TGT  = CNT_W'(DEATH_FRAMES);
  localparam logic [CNT_W-1:0]   INVULN_TGT = CNT_W'(INVULN_FRAMES);

  lives_state_t       state_r, next_state_s;
  logic [LIVES_W-1:0] lives_r, lives_next_s;
  logic               collision_d_r;
  logic               hit_s, bonus_s;
  logic               timer_clear_s, timer_done_s;
  logic [CNT_W-1:0]   timer_target_s, frame_count_s;
  logic               life_lost_next_s, respawn_next_s;
  logic               blink_r, freeze_r, respawn_r, life_lost_r, game_over_r;

  assign hit_s = bus.collision & ~collision_d_r;

`ifdef LIVES_BONUS_EN
  assign bonus_s = bus.bonusLife;
`else
  assign bonus_s = 1'b0;
`endif

  // The counter restarts on every state change, so a frame coinciding with the hit is not counted
  assign timer_clear_s  = (next_state_s != state_r) || !((state_r == DYING) || (state_r == INVULN));
  assign timer_target_s = (state_r == DYING) ? DEATH_TGT : INVULN_TGT;

  frame_timer #(.CNT_W(CNT_W)) u_timer (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (timer_clear_s),
    .startOfFrame (bus.startOfFrame),
    .target       (timer_target_s),
    .done         (timer_done_s),
    .count        (frame_count_s)
  );

  // Next-state, lives and pulse decode; a hit beats a same-cycle bonus
  always_comb begin
    next_state_s     = state_r;
    lives_next_s     = lives_r;
    life_lost_next_s = 1'b0;
    respawn_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.startGame) begin
          next_state_s = PLAYING;
          lives_next_s = MAX_L;
        end else begin
          next_state_s = IDLE;
        end
      end
      PLAYING: begin
        if (hit_s) begin
          next_state_s     = DYING;
          lives_next_s     = sat_dec(lives_r);
          life_lost_next_s = 1'b1;
        end else if (bonus_s) begin
          lives_next_s = sat_inc(lives_r, MAX_L);
        end else begin
          lives_next_s = lives_r;
        end
      end
      DYING: begin
        if (timer_done_s && (lives_r == {LIVES_W{1'b0}})) begin
          next_state_s = GAME_OVER;
        end else if (timer_done_s) begin
          next_state_s   = INVULN;
          respawn_next_s = 1'b1;
        end else begin
          next_state_s = DYING;
        end
      end
      INVULN: begin
        if (timer_done_s) begin
          next_state_s = PLAYING;
        end else begin
          next_state_s = INVULN;
        end
        if (bonus_s) begin
          lives_next_s = sat_inc(lives_r, MAX_L);
        end else begin
          lives_next_s = lives_r;
        end
      end
      GAME_OVER: begin
        if (bus.startGame) begin
          next_state_s = PLAYING;
          lives_next_s = MAX_L;
        end else begin
          lives_next_s = {LIVES_W{1'b0}};
        end
      end
      default: begin
        next_state_s = IDLE;
        lives_next_s = MAX_L;
      end
    endcase
  end

  // State, lives and registered outputs
  always_ff @(posedge clk) begin
    if (resetN) begin
      state_r       <= IDLE;
      lives_r       <= MAX_L;
      collision_d_r <= 1'b0;
      blink_r       <= 1'b0;
      freeze_r      <= 1'b0;
      respawn_r     <= 1'b0;
      life_lost_r   <= 1'b0;
      game_over_r   <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      lives_r       <= lives_next_s;
      collision_d_r <= bus.collision;
      blink_r       <= (state_r == INVULN) && (next_state_s == INVULN) && frame_count_s[BLINK_SHIFT];
      freeze_r      <= (next_state_s == DYING);
      respawn_r     <= respawn_next_s;
      life_lost_r   <= life_lost_next_s;
      game_over_r   <= (next_state_s == GAME_OVER);
    end
  end

  assign bus.numOfLives    = lives_r;
  assign bus.monkeyBlink   = blink_r;
  assign bus.freezeMonkey  = freeze_r;
  assign bus.respawnPulse  = respawn_r;
  assign bus.lifeLostPulse = life_lost_r;
  assign bus.gameOver      = game_over_r;

endmodule

// File: tb/tb_lives_counter.sv
// Scoreboard bench for lives_counter: expected pulse events are queued by the stimulus
// and popped by a monitor; level outputs are checked directly at chosen points.
module tb_lives_counter;

  localparam int FRAME_LEN = 16;

  typedef enum int {EV_LOST = 0, EV_RESP = 1, EV_GO = 2} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [1:0] lives;
  } ev_t;

  logic clk;
  logic resetN;
  lives_counter_if bus_if ();

  lives_counter dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_if.slave)
  );

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  int  phase = 0;
  int  sof_total = 0;
  int  mark = 0;
  logic go_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_ev(input ev_kind_t k, input logic [1:0] l);
    ev_t e;
    e.kind  = k;
    e.lives = l;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_t k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d lives %0d expected none", k, bus_if.numOfLives);
    end else begin
      e = exp_q.pop_front();
      if ((e.kind != k) || (e.lives !== bus_if.numOfLives)) begin
        errors++;
        $display("FAIL event: got kind %0d lives %0d expected kind %0d lives %0d",
                 k, bus_if.numOfLives, e.kind, e.lives);
      end
    end
  endtask

  // Advance n cycles, issuing startOfFrame every FRAME_LEN cycles
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.startOfFrame = (phase == FRAME_LEN - 1);
      if (phase == FRAME_LEN - 1) sof_total++;
      phase = (phase + 1) % FRAME_LEN;
      @(negedge clk);
    end
    bus_if.startOfFrame = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      int s;
      s = sof_total;
      while (sof_total == s) run(1);
    end
  endtask

  task automatic frames_to(input int k);
    frames(k - (sof_total - mark));
  endtask

  task automatic pulse_start();
    bus_if.startGame = 1'b1;
    run(1);
    bus_if.startGame = 1'b0;
  endtask

  task automatic invuln_point(input int k, input bit with_hit);
    frames_to(k);
    bus_if.collision = with_hit;
    run(2);
    bus_if.collision = 1'b0;
    check($sformatf("blink_f%0d", k), {31'd0, bus_if.monkeyBlink}, (k >> 3) & 1);
    check($sformatf("lives_f%0d", k), {30'd0, bus_if.numOfLives}, 32'd2);
  endtask

  // Monitor: every output pulse (and gameOver rise) must match the next queued event
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.lifeLostPulse === 1'b1) check_ev(EV_LOST);
      if (bus_if.respawnPulse === 1'b1) check_ev(EV_RESP);
      if ((bus_if.gameOver === 1'b1) && !go_prev) check_ev(EV_GO);
      go_prev = (bus_if.gameOver === 1'b1);
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetN              = 1'b1;
    bus_if.startOfFrame = 1'b0;
    bus_if.startGame    = 1'b0;
    bus_if.collision    = 1'b0;
    bus_if.bonusLife    = 1'b0;
    @(negedge clk);
    run(2);
    resetN = 1'b0;
    check("rst_lives", {30'd0, bus_if.numOfLives}, 32'd3);
    check("rst_gameover", {31'd0, bus_if.gameOver}, 32'd0);
    check("rst_freeze", {31'd0, bus_if.freezeMonkey}, 32'd0);
    check("rst_blink", {31'd0, bus_if.monkeyBlink}, 32'd0);
    pulse_start();
    check("start_lives", {30'd0, bus_if.numOfLives}, 32'd3);
    check("start_gameover", {31'd0, bus_if.gameOver}, 32'd0);
    check("start_lost", {31'd0, bus_if.lifeLostPulse}, 32'd0);

    // Held collision costs one life, then DYING for exactly 30 frames
    bus_if.collision = 1'b1;
    expect_ev(EV_LOST, 2'd2);
    expect_ev(EV_RESP, 2'd2);
    run(1);
    check("hit_lives", {30'd0, bus_if.numOfLives}, 32'd2);
    check("hit_freeze", {31'd0, bus_if.freezeMonkey}, 32'd1);
    frames(30);
    check("dying_30f_freeze", {31'd0, bus_if.freezeMonkey}, 32'd1);
    run(1);
    mark = sof_total;
    check("respawn_freeze", {31'd0, bus_if.freezeMonkey}, 32'd0);
    run(19);
    bus_if.collision = 1'b0;

    // Invulnerability window: hits ignored, blink follows frame count bit 3
    invuln_point(5, 1'b1);
    invuln_point(8, 1'b0);
    invuln_point(12, 1'b0);
    invuln_point(16, 1'b0);
    invuln_point(24, 1'b0);
    invuln_point(40, 1'b1);
    invuln_point(89, 1'b1);
    frames_to(91);
    check("playing_blink", {31'd0, bus_if.monkeyBlink}, 32'd0);
    bus_if.collision = 1'b1;
    expect_ev(EV_LOST, 2'd1);
    expect_ev(EV_RESP, 2'd1);
    run(1);
    check("hit2_lives", {30'd0, bus_if.numOfLives}, 32'd1);
    run(3);
    bus_if.collision = 1'b0;
    frames(30);
    run(1);
    mark = sof_total;

    // Rising edge on the INVULN->PLAYING cycle is ignored
    frames_to(90);
    bus_if.collision = 1'b1;
    run(1);
    run(5);
    bus_if.collision = 1'b0;
    run(3);
    check("edge_exit_lives", {30'd0, bus_if.numOfLives}, 32'd1);
    check("edge_exit_freeze", {31'd0, bus_if.freezeMonkey}, 32'd0);

    // Last life: game over with no respawn
    bus_if.collision = 1'b1;
    expect_ev(EV_LOST, 2'd0);
    expect_ev(EV_GO, 2'd0);
    run(1);
    check("hit3_lives", {30'd0, bus_if.numOfLives}, 32'd0);
    run(3);
    bus_if.collision = 1'b0;
    frames(30);
    check("pre_go", {31'd0, bus_if.gameOver}, 32'd0);
    run(1);
    check("go_level", {31'd0, bus_if.gameOver}, 32'd1);
    check("go_lives", {30'd0, bus_if.numOfLives}, 32'd0);
    run(4);
    pulse_start();
    check("restart_lives", {30'd0, bus_if.numOfLives}, 32'd3);
    check("restart_go", {31'd0, bus_if.gameOver}, 32'd0);

    // startGame ignored in DYING, then reset mid-DYING aborts without respawn
    bus_if.collision = 1'b1;
    expect_ev(EV_LOST, 2'd2);
    run(1);
    bus_if.collision = 1'b0;
    pulse_start();
    check("dying_start_lives", {30'd0, bus_if.numOfLives}, 32'd2);
    check("dying_start_freeze", {31'd0, bus_if.freezeMonkey}, 32'd1);
    frames(10);
    resetN = 1'b1;
    run(1);
    resetN = 1'b0;
    check("midrst_lives", {30'd0, bus_if.numOfLives}, 32'd3);
    check("midrst_freeze", {31'd0, bus_if.freezeMonkey}, 32'd0);
    frames(25);
    bus_if.collision = 1'b1;
    run(2);
    bus_if.collision = 1'b0;
    run(2);
    check("idle_hit_lives", {30'd0, bus_if.numOfLives}, 32'd3);
    pulse_start();
    check("start2_lives", {30'd0, bus_if.numOfLives}, 32'd3);

    // Bonus life behaviour
    bus_if.collision = 1'b1;
    expect_ev(EV_LOST, 2'd2);
    expect_ev(EV_RESP, 2'd2);
    run(1);
    run(2);
    bus_if.collision = 1'b0;
    bus_if.bonusLife = 1'b1;
    run(1);
    bus_if.bonusLife = 1'b0;
    run(1);
    check("bonus_dying", {30'd0, bus_if.numOfLives}, 32'd2);
    frames(30);
    run(1);
    mark = sof_total;
    bus_if.bonusLife = 1'b1;
    run(1);
    bus_if.bonusLife = 1'b0;
    run(1);
`ifdef LIVES_BONUS_EN
    check("bonus_inc", {30'd0, bus_if.numOfLives}, 32'd3);
    bus_if.bonusLife = 1'b1;
    run(1);
    bus_if.bonusLife = 1'b0;
    run(1);
    check("bonus_sat", {30'd0, bus_if.numOfLives}, 32'd3);
    frames_to(91);
    bus_if.collision = 1'b1;
    bus_if.bonusLife = 1'b1;
    expect_ev(EV_LOST, 2'd2);
    run(1);
    bus_if.bonusLife = 1'b0;
    bus_if.collision = 1'b0;
    check("hit_beats_bonus", {30'd0, bus_if.numOfLives}, 32'd2);
    run(3);
`else
    check("bonus_disabled", {30'd0, bus_if.numOfLives}, 32'd2);
    run(3);
`endif

    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
